// File: rtl/vector_div_pkg.sv
// Shared types and saturation helpers for the sequential vector divider.
package vector_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        FIX,
        DONE
    } state_e;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_RET = 1'b1;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/seq_divider_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
module seq_divider_core #(
    parameter int NW = 25,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] quo
);

    localparam int CW = $clog2(NW + 1);

    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] den_q, den_d;
    logic [NW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   trial;
    logic [DW:0]   diff;
    logic          ge;

    assign busy = (cnt_q != '0);
    // done marks the cycle whose closing edge retires the last bit
    assign done = (cnt_q == CW'(1));
    assign quo  = quo_q;

    always_comb begin
        rem_d = rem_q;
        den_d = den_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        trial = {rem_q, quo_q[NW-1]};
        diff  = trial - {1'b0, den_q};
        ge    = (trial >= {1'b0, den_q});
        if (start) begin
            rem_d = '0;
            den_d = den;
            quo_d = num;
            cnt_d = CW'(NW);
        end else if (busy) begin
            rem_d = ge ? diff[DW-1:0] : trial[DW-1:0];
            quo_d = {quo_q[NW-2:0], ge};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            den_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            den_q <= den_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vector_divider_seq.sv
// Multi-lane signed fixed-point divider / return calculator sharing one
// restoring divider across the lanes in turn.
module vector_divider_seq
    import vector_div_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                   clk_100mhz,
    input  logic                   reset,
    input  logic                   valid,
    output logic                   ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic                   sel,
    output logic [LANES*WIDTH-1:0] c,
    output logic [LANES-1:0]       dz,
    output logic [LANES-1:0]       sat,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int QW = WIDTH + FRAC + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]    LAST   = LW'(LANES - 1);
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] C_MIN  = WIDTH'(sat_min(WIDTH));
    localparam logic [QW-1:0]    Q_MAX  = QW'(sat_max(WIDTH));
    localparam logic [QW-1:0]    Q_MINA = QW'(-sat_min(WIDTH));

    state_e                 state_q, state_d;
    logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [LANES-1:0]       dz_q, dz_d, sat_q, sat_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic                   sel_q, sel_d;
    logic                   neg_q, neg_d;
    logic                   dzl_q, dzl_d;
    logic                   nneg_q, nneg_d;
    logic                   ready_q, ready_d;
    logic                   ov_q, ov_d;

    logic [WIDTH-1:0] a_l, b_l, c_l, den;
    logic [WIDTH:0]   n_s, d_s, n_abs;
    logic [QW-1:0]    num, quo;
    logic             sat_l, start, div_busy, div_done;

    assign ready     = ready_q;
    assign out_valid = ov_q;
    assign c         = c_q;
    assign dz        = dz_q;
    assign sat       = sat_q;

    // N is one bit wider than the operands so b-a never wraps
    always_comb begin
        a_l = a_q[int'(lane_q)*WIDTH +: WIDTH];
        b_l = b_q[int'(lane_q)*WIDTH +: WIDTH];
        if (sel_q == MODE_RET) begin
            n_s = {b_l[WIDTH-1], b_l} - {a_l[WIDTH-1], a_l};
            d_s = {a_l[WIDTH-1], a_l};
        end else begin
            n_s = {a_l[WIDTH-1], a_l};
            d_s = {b_l[WIDTH-1], b_l};
        end
        n_abs = n_s[WIDTH] ? (~n_s + (WIDTH+1)'(1)) : n_s;
        den   = d_s[WIDTH] ? (~d_s[WIDTH-1:0] + WIDTH'(1))
                           : d_s[WIDTH-1:0];
        num   = QW'(n_abs) << FRAC;
        start = (state_q == LOAD) && !div_busy;
    end

    seq_divider_core #(
        .NW (QW),
        .DW (WIDTH)
    ) u_core (
        .clk   (clk_100mhz),
        .rst_n (reset),
        .start (start),
        .num   (num),
        .den   (den),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (quo)
    );

    always_comb begin
        c_l   = quo[WIDTH-1:0];
        sat_l = 1'b0;
        if (dzl_q) begin
            c_l = nneg_q ? C_MAX : C_MIN;
        end else if (neg_q) begin
            c_l = ~quo[WIDTH-1:0] + WIDTH'(1);
            if (quo > Q_MINA) begin
                c_l   = C_MIN;
                sat_l = 1'b1;
            end
        end else if (quo > Q_MAX) begin
            c_l   = C_MAX;
            sat_l = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        dz_d    = dz_q;
        sat_d   = sat_q;
        lane_d  = lane_q;
        sel_d   = sel_q;
        neg_d   = neg_q;
        dzl_d   = dzl_q;
        nneg_d  = nneg_q;
        unique case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sel;
                    lane_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                neg_d   = n_s[WIDTH] ^ d_s[WIDTH];
                dzl_d   = (d_s == '0);
                nneg_d  = ~n_s[WIDTH];
                state_d = DIV;
            end
            DIV: begin
                if (div_done) state_d = FIX;
            end
            FIX: begin
                c_d[int'(lane_q)*WIDTH +: WIDTH] = c_l;
                dz_d[lane_q]  = dzl_q;
                sat_d[lane_q] = sat_l;
                if (lane_q == LAST) begin
                    state_d = DONE;
                end else begin
                    lane_d  = lane_q + LW'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        ov_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            dz_q    <= '0;
            sat_q   <= '0;
            lane_q  <= '0;
            sel_q   <= 1'b0;
            neg_q   <= 1'b0;
            dzl_q   <= 1'b0;
            nneg_q  <= 1'b0;
            ready_q <= 1'b1;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
            sat_q   <= sat_d;
            lane_q  <= lane_d;
            sel_q   <= sel_d;
            neg_q   <= neg_d;
            dzl_q   <= dzl_d;
            nneg_q  <= nneg_d;
            ready_q <= ready_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_vector_divider_seq.sv
// Directed bench for vector_divider_seq with hand-computed expectations.
module tb_vector_divider_seq;

    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LAT   = 108;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        sel = 1'b0;
    logic [63:0] c;
    logic [3:0]  dz;
    logic [3:0]  sat;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_divider_seq #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk_100mhz (clk),
        .reset      (reset),
        .valid      (valid),
        .ready      (ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .c          (c),
        .dz         (dz),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int v0, input int v1,
                                       input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    task automatic start_txn(input logic s, input logic [63:0] av,
                             input logic [63:0] bv);
        @(negedge clk);
        check("ready_idle", 64'(ready), 64'(1));
        valid = 1'b1;
        sel   = s;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        check("ready_fall", 64'(ready), 64'(0));
        @(negedge clk);
        valid = 1'b0;
        sel   = ~s;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
    endtask

    task automatic run_txn(input string nm, input logic s,
                           input logic [63:0] av, input logic [63:0] bv,
                           input logic [63:0] ec, input logic [3:0] edz,
                           input logic [3:0] esat, input int hold);
        int lat;
        logic ok;
        out_ready = (hold == 0);
        start_txn(s, av, bv);
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(LAT));
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s_c%0d", nm, i), 64'(c[i*16 +: 16]),
                  64'(ec[i*16 +: 16]));
        check({nm, "_dz"}, 64'(dz), 64'(edz));
        check({nm, "_sat"}, 64'(sat), 64'(esat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid = (i == 5);
            a     = pk(1, 2, 3, 4);
            b     = pk(1, 1, 1, 1);
            @(posedge clk);
            #1;
            ok = (c == ec) && (dz == edz) && (sat == esat) &&
                 out_valid && !ready;
            check({nm, "_hold_stable"}, 64'(ok), 64'(1));
        end
        if (hold > 0) begin
            @(negedge clk);
            valid     = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({nm, "_ov_drop"}, 64'(out_valid), 64'(0));
        check({nm, "_ready_rise"}, 64'(ready), 64'(1));
        @(posedge clk);
        #1;
        check({nm, "_stay_idle"}, 64'(ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_ov", 64'(out_valid), 64'(0));
        check("rst_c", c, 64'(0));
        check("rst_dz", 64'(dz), 64'(0));
        check("rst_sat", 64'(sat), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        run_txn("ret", 1'b1, pk(100, 200, 300, 400),
                pk(110, 210, 310, 410), pk(25, 12, 8, 6),
                4'b0000, 4'b0000, 0);
        run_txn("div", 1'b0, pk(768, -768, 256, 0),
                pk(-256, 256, 512, 100), pk(-768, -768, 128, 0),
                4'b0000, 4'b0000, 0);
        run_txn("sat", 1'b0, pk(32767, -32768, 1, -1),
                pk(1, 1, -1, -1), pk(32767, -32768, -256, 256),
                4'b0000, 4'b0011, 0);
        run_txn("dz", 1'b0, pk(5, -5, 0, 7), pk(0, 0, 0, 1),
                pk(32767, -32768, 32767, 1792), 4'b0111, 4'b0000, 0);
        run_txn("bp", 1'b0, pk(768, -768, 256, 0),
                pk(-256, 256, 512, 100), pk(-768, -768, 128, 0),
                4'b0000, 4'b0000, 20);

        start_txn(1'b1, pk(100, 200, 300, 400), pk(110, 210, 310, 410));
        repeat (2 * 27 + 5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_ov", 64'(out_valid), 64'(0));
        check("mid_rst_c", c, 64'(0));
        check("mid_rst_ready", 64'(ready), 64'(1));
        check("mid_rst_dz_sat", 64'({dz, sat}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_txn("post", 1'b0, pk(32767, -32768, 1, -1),
                pk(1, 1, -1, -1), pk(32767, -32768, -256, 256),
                4'b0000, 4'b0011, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
